// File: rtl/axis_client_arbiter_pkg.sv
// Shared widths, FSM state type and index-width helper for the client arbiter.
package axis_client_arbiter_pkg;

    localparam int ARB_NUM_CLIENTS = 4;
    localparam int ARB_DATAW       = 32;
    localparam int ARB_DESTW       = 4;
    localparam int ARB_IDW         = 4;
    localparam int ARB_MAX_DATAW   = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ARB_IDXW = idx_width(ARB_NUM_CLIENTS);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXIS register slice: registered ready, registered outputs, 1-cycle latency.
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         push;

    // Full only when the skid entry is occupied, so ready is a pure register.
    assign in_ready = ~skid_valid;
    assign push     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= push;
                if (push) out_data <= in_data;
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/axis_client_arbiter.sv
// Packet-level round-robin arbiter merging client streams onto one AXIS NoC port.
module axis_client_arbiter
    import axis_client_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = ARB_NUM_CLIENTS,
    parameter int DATAW       = ARB_DATAW,
    parameter int DESTW       = ARB_DESTW,
    parameter int IDW         = ARB_IDW,
    parameter int MAX_DATAW   = ARB_MAX_DATAW,
    parameter int IDXW        = idx_width(NUM_CLIENTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CLIENTS-1:0]       client_tvalid,
    input  logic [NUM_CLIENTS-1:0]       client_tlast,
    input  logic [NUM_CLIENTS*DATAW-1:0] client_tdata,
    input  logic [NUM_CLIENTS*DESTW-1:0] client_tdest,
    output logic [NUM_CLIENTS-1:0]       client_tready,
    output logic                         axis_tvalid,
    input  logic                         axis_tready,
    output logic                         axis_tlast,
    output logic [DESTW-1:0]             axis_tdest,
    output logic [IDW-1:0]               axis_tid,
    output logic [MAX_DATAW-1:0]         axis_tdata,
    output logic                         busy,
    output logic [IDXW-1:0]              grant_idx,
    output logic [31:0]                  pkt_count
);

    localparam int PAYW = 1 + DESTW + IDW + MAX_DATAW;

    arb_state_e       state;
    logic [IDXW-1:0]  rr_ptr;
    logic             slice_ready;
    logic             accept;
    logic             g_valid;
    logic             g_last;
    logic [DATAW-1:0] g_data;
    logic [DESTW-1:0] g_dest;
    logic [PAYW-1:0]  slice_in;
    logic [PAYW-1:0]  slice_out;

    // First requester at or after ptr, wrapping; lowest offset wins.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                input logic [IDXW-1:0] ptr);
        int idx;
        rr_pick = ptr;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CLIENTS;
            if (req[idx]) rr_pick = IDXW'(idx);
        end
    endfunction

    function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] g);
        return (int'(g) + 1 >= NUM_CLIENTS) ? '0 : IDXW'(int'(g) + 1);
    endfunction

    always_comb begin
        g_valid       = client_tvalid[grant_idx];
        g_last        = client_tlast[grant_idx];
        g_data        = client_tdata[int'(grant_idx)*DATAW +: DATAW];
        g_dest        = client_tdest[int'(grant_idx)*DESTW +: DESTW];
        client_tready = '0;
        if (state == ST_LOCKED) client_tready[grant_idx] = slice_ready;
        accept        = (state == ST_LOCKED) && g_valid && slice_ready;
    end

    assign slice_in = {g_last, g_dest, IDW'(grant_idx), MAX_DATAW'(g_data)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            pkt_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|client_tvalid) begin
                        grant_idx <= rr_pick(client_tvalid, rr_ptr);
                        state     <= ST_LOCKED;
                        busy      <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Lock is released only by an accepted tlast; a stalled client holds it.
                    if (accept && g_last) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        rr_ptr    <= rr_next(grant_idx);
                        pkt_count <= pkt_count + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .W(PAYW)
    ) u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (accept),
        .in_ready (slice_ready),
        .in_data  (slice_in),
        .out_valid(axis_tvalid),
        .out_ready(axis_tready),
        .out_data (slice_out)
    );

    assign {axis_tlast, axis_tdest, axis_tid, axis_tdata} = slice_out;

endmodule

// File: tb/tb_axis_client_arbiter.sv
// Directed bench for axis_client_arbiter: arbitration order, locking, backpressure, reset.
module tb_axis_client_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   client_tvalid;
    logic [3:0]   client_tlast;
    logic [127:0] client_tdata;
    logic [15:0]  client_tdest;
    logic [3:0]   client_tready;
    logic         axis_tvalid;
    logic         axis_tready;
    logic         axis_tlast;
    logic [3:0]   axis_tdest;
    logic [3:0]   axis_tid;
    logic [63:0]  axis_tdata;
    logic         busy;
    logic [1:0]   grant_idx;
    logic [31:0]  pkt_count;

    axis_client_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .client_tvalid(client_tvalid),
        .client_tlast (client_tlast),
        .client_tdata (client_tdata),
        .client_tdest (client_tdest),
        .client_tready(client_tready),
        .axis_tvalid  (axis_tvalid),
        .axis_tready  (axis_tready),
        .axis_tlast   (axis_tlast),
        .axis_tdest   (axis_tdest),
        .axis_tid     (axis_tid),
        .axis_tdata   (axis_tdata),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // per-client beat sources: {tlast, data}
    logic [32:0] src_mem [4][8];
    int          src_n [4];
    int          src_p [4];
    logic [3:0]  hold;

    // observed output beats
    logic [63:0] lg_data [64];
    logic [3:0]  lg_tid  [64];
    logic [3:0]  lg_dest [64];
    logic        lg_last [64];
    int          lg_cyc  [64];
    int          lg_n;

    // expected output beats
    logic [63:0] ex_data [64];
    logic [3:0]  ex_tid  [64];
    logic        ex_last [64];
    int          ex_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (!hold[i] && src_p[i] < src_n[i]) begin
                client_tvalid[i]         = 1'b1;
                client_tlast[i]          = src_mem[i][src_p[i]][32];
                client_tdata[i*32 +: 32] = src_mem[i][src_p[i]][31:0];
            end else begin
                client_tvalid[i]         = 1'b0;
                client_tlast[i]          = 1'b0;
                client_tdata[i*32 +: 32] = '0;
            end
        end
    endtask

    task automatic load(input int c, input int n, input logic [31:0] base);
        src_n[c] = n;
        src_p[c] = 0;
        for (int k = 0; k < n; k++) src_mem[c][k] = {(k == n - 1), base + 32'(k)};
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
        end
        hold = '0;
    endtask

    task automatic expect_beat(input logic [63:0] d, input logic [3:0] t, input logic l);
        ex_data[ex_n] = d;
        ex_tid[ex_n]  = t;
        ex_last[ex_n] = l;
        ex_n++;
    endtask

    // One clock: sample before the edge, update sources after it.
    task automatic tick();
        logic [3:0]  acc;
        logic        stalled;
        logic [63:0] p_data;
        logic [3:0]  p_tid;
        logic        p_last;
        #1;
        chk("onehot_ready", 64'($countones(client_tready) <= 1), 64'd1);
        acc = client_tvalid & client_tready;
        if (axis_tvalid && axis_tready && lg_n < 64) begin
            lg_data[lg_n] = axis_tdata;
            lg_tid[lg_n]  = axis_tid;
            lg_dest[lg_n] = axis_tdest;
            lg_last[lg_n] = axis_tlast;
            lg_cyc[lg_n]  = cyc;
            lg_n++;
        end
        stalled = axis_tvalid && !axis_tready;
        p_data  = axis_tdata;
        p_tid   = axis_tid;
        p_last  = axis_tlast;
        @(posedge clk);
        #1;
        cyc++;
        if (stalled) begin
            chk("stall_valid", axis_tvalid, 1);
            chk("stall_data", axis_tdata, p_data);
            chk("stall_tid", axis_tid, p_tid);
            chk("stall_last", axis_tlast, p_last);
        end
        for (int i = 0; i < 4; i++) if (acc[i]) src_p[i]++;
        drive();
    endtask

    task automatic drain();
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            done = !axis_tvalid;
            for (int i = 0; i < 4; i++) if (src_p[i] < src_n[i]) done = 1'b0;
            if (!done) begin
                tick();
                n++;
            end
        end
        chk("drain_timeout", done, 1);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, lg_n, ex_n);
        for (int i = 0; i < ex_n && i < lg_n; i++) begin
            chk({tag, "_data"}, lg_data[i], ex_data[i]);
            chk({tag, "_tid"}, lg_tid[i], ex_tid[i]);
            chk({tag, "_last"}, lg_last[i], ex_last[i]);
            chk({tag, "_dest"}, lg_dest[i], 4'(ex_tid[i] + 4'd5));
        end
        lg_n = 0;
        ex_n = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        lg_n = 0;
        ex_n = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        axis_tready = 1'b1;
        client_tvalid = '0;
        client_tlast = '0;
        client_tdata = '0;
        for (int i = 0; i < 4; i++) client_tdest[i*4 +: 4] = 4'(i + 5);
        lg_n = 0;
        ex_n = 0;
        clear_src();
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", axis_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", client_tready, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_tdata", axis_tdata, 0);
        rst_n = 1'b1;

        // single client 0 packet 10,11,12
        load(0, 3, 32'd10);
        drive();
        tick();
        chk("t1_busy_lock", busy, 1);
        chk("t1_grant", grant_idx, 0);
        tick();
        tick();
        tick();
        chk("t1_busy_fall", busy, 0);
        chk("t1_pkt", pkt_count, 1);
        drain();
        chk("t1_consec_a", 64'(lg_cyc[1] - lg_cyc[0]), 1);
        chk("t1_consec_b", 64'(lg_cyc[2] - lg_cyc[1]), 1);
        expect_beat(64'd10, 4'd0, 1'b0);
        expect_beat(64'd11, 4'd0, 1'b0);
        expect_beat(64'd12, 4'd0, 1'b1);
        check_log("t1");

        // all four clients, 2-beat packets, from reset
        do_reset();
        for (int c = 0; c < 4; c++) load(c, 2, 32'(c * 16));
        drive();
        drain();
        chk("t2_pkt", pkt_count, 4);
        for (int c = 0; c < 4; c++) begin
            expect_beat(64'(c * 16), 4'(c), 1'b0);
            expect_beat(64'(c * 16 + 1), 4'(c), 1'b1);
        end
        check_log("t2");

        // client 1 stalls mid-packet while client 2 waits
        load(1, 3, 32'h100);
        load(2, 2, 32'h200);
        drive();
        tick();
        chk("t3_grant", grant_idx, 1);
        tick();
        hold[1] = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_c2_wait", client_tready[2], 0);
            chk("t3_locked", grant_idx, 1);
        end
        hold[1] = 1'b0;
        drive();
        drain();
        chk("t3_pkt", pkt_count, 6);
        expect_beat(64'h100, 4'd1, 1'b0);
        expect_beat(64'h101, 4'd1, 1'b0);
        expect_beat(64'h102, 4'd1, 1'b1);
        expect_beat(64'h200, 4'd2, 1'b0);
        expect_beat(64'h201, 4'd2, 1'b1);
        check_log("t3");

        // backpressure 1,0,0,1 during a 4-beat packet
        load(0, 4, 32'h40);
        drive();
        axis_tready = 1'b1;
        tick();
        tick();
        axis_tready = 1'b0;
        tick();
        chk("t4_full_ready", client_tready, 0);
        chk("t4_stall_valid", axis_tvalid, 1);
        tick();
        chk("t4_full_ready2", client_tready, 0);
        axis_tready = 1'b1;
        drain();
        chk("t4_pkt", pkt_count, 7);
        for (int k = 0; k < 4; k++) expect_beat(64'(32'h40 + 32'(k)), 4'd0, k == 3);
        check_log("t4");

        // reset after beat 2 of 4, then client 3 sends
        load(0, 4, 32'h50);
        drive();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_tvalid", axis_tvalid, 0);
        chk("t5_tdata", axis_tdata, 0);
        chk("t5_tid", axis_tid, 0);
        chk("t5_tlast", axis_tlast, 0);
        chk("t5_tdest", axis_tdest, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", client_tready, 0);
        chk("t5_pkt0", pkt_count, 0);
        chk("t5_grant", grant_idx, 0);
        do_reset();
        load(3, 2, 32'h30);
        drive();
        drain();
        chk("t5_pkt", pkt_count, 1);
        expect_beat(64'h30, 4'd3, 1'b0);
        expect_beat(64'h31, 4'd3, 1'b1);
        check_log("t5");

        // client 2 single beat finishes, then 1 and 3 compete: 3 wins
        load(2, 1, 32'h22);
        drive();
        tick();
        chk("t6_grant2", grant_idx, 2);
        load(1, 2, 32'h110);
        load(3, 2, 32'h330);
        drive();
        tick();
        chk("t6_idle", busy, 0);
        tick();
        chk("t6_grant3", grant_idx, 3);
        chk("t6_busy", busy, 1);
        drain();
        chk("t6_pkt", pkt_count, 4);
        expect_beat(64'h22, 4'd2, 1'b1);
        expect_beat(64'h330, 4'd3, 1'b0);
        expect_beat(64'h331, 4'd3, 1'b1);
        expect_beat(64'h110, 4'd1, 1'b0);
        expect_beat(64'h111, 4'd1, 1'b1);
        check_log("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_client_arbiter.md
Name: axis_client_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXIS NoC injection port among NUM_CLIENTS client stream sources.
- Each source is a client front-end with a FIFO and tlast tagging.
- Sits between the client front-ends and the NoC router port feeding the adder. A granted client holds the port until its tlast beat is accepted, so packets never interleave.
- Stamps tid with the source index so the adder can tell streams apart. The output is registered through a skid buffer.

Parameters:
- NUM_CLIENTS, 4, number of requesting client streams (1..16)
- DATAW, `DATAW, client payload width
- DESTW, `AXIS_DESTW, NoC destination width
- IDW, `AXIS_IDW, NoC id width; must be >= IDXW
- MAX_DATAW, `AXIS_MAX_DATAW, NoC data width; must be >= DATAW
- IDXW, derived max(1, clog2(NUM_CLIENTS)), grant index width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- client_tvalid  in  NUM_CLIENTS  per-client beat valid
- client_tlast  in  NUM_CLIENTS  per-client last beat of packet
- client_tdata  in  NUM_CLIENTS*DATAW  flattened payload; client i at [i*DATAW +: DATAW]
- client_tdest  in  NUM_CLIENTS*DESTW  flattened destination per client
- client_tready  out  NUM_CLIENTS  per-client ready; at most one bit high
- axis_tvalid  out  1  NoC beat valid
- axis_tready  in  1  NoC ready
- axis_tlast  out  1  last beat
- axis_tdest  out  DESTW  destination of the granted client
- axis_tid  out  IDW  granted client index, zero-extended
- axis_tdata  out  MAX_DATAW  payload, zero-extended from DATAW
- busy  out  1  high while a packet is locked
- grant_idx  out  IDXW  currently or last granted client
- pkt_count  out  32  count of completed packets; wraps at 2^32

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; rr_ptr=0; grant_idx=0; pkt_count=0; skid buffer empty.
  - All outputs 0, including client_tready, axis_tvalid and busy.
  - Deassertion is sampled synchronously; first arbitration happens on the first clk edge after release.
- FSM states: IDLE, LOCKED.
- IDLE:
  - All client_tready=0.
  - If any client_tvalid is high, select the first index i with client_tvalid[i] set, searching circularly from rr_ptr.
  - On the next edge: grant_idx<=i, state<=LOCKED, busy<=1.
  - This costs exactly one arbitration bubble cycle per packet.
- LOCKED:
  - client_tready[grant_idx]=slice_ready; all other client_tready=0.
  - Beat accept = client_tvalid[g] && client_tready[g]. Each accepted beat is pushed into the skid buffer with tid=g, tdest/tdata from client g, and tlast.
  - An accepted beat with tlast=1 causes, on that edge: state<=IDLE, busy<=0, rr_ptr<=(g+1) mod NUM_CLIENTS, pkt_count<=pkt_count+1.
  - If the granted client drops tvalid mid-packet, the lock is held indefinitely; there is no timeout and other clients keep waiting.
- Skid buffer (output register slice):
  - 2 entries. slice_ready comes from a register and is 1 when the buffer is not full.
  - Full throughput of 1 beat/cycle when axis_tready=1.
  - Latency from accept to axis_tvalid is 1 cycle.
  - axis_* outputs are driven only from registers.
  - While axis_tvalid=1 and axis_tready=0, all axis_* outputs hold stable (AXIS rule).
  - Beat order is preserved.
- Simultaneous requests: arbitration order is rr_ptr, rr_ptr+1, ... with wrap. A client that just finished has lowest priority next round.
- NUM_CLIENTS=1: rr_ptr stays 0; behaviour is otherwise identical.
- Single-beat packet (tlast on the first beat): lock lasts one accept; the next arbitration follows immediately.
- Reset mid-packet: the partial packet is discarded, including beats in the skid buffer. Clients must restart the packet after reset.
- A tvalid that rises in IDLE on a client other than the winner waits; no beat is accepted in IDLE.

Decomposition:
- Add ARB_NUM_CLIENTS and ARB_IDXW defines to static_params.vh next to the AXIS width defines, for top-level instantiation.
- The round-robin search is a function inside the module.
- Sub-module: axis_skid_buffer, parameterised by payload width. The payload is {tlast, tdest, tid, tdata}. The block is reusable at other NoC boundaries.

Test Plan:
- Single client 0 sends 3 beats (10,11,12, tlast on 12), axis_tready=1 → axis_tdata 10,11,12 on consecutive cycles; tid=0; tlast only on 12; pkt_count=1; busy falls after the 12 accept.
- Clients 0–3 all valid with 2-beat packets from reset → grant order 0,1,2,3; axis_tid sequence 0,0,1,1,2,2,3,3; no interleaving; pkt_count=4.
- Client 1 packet in progress; client 1 holds tvalid low for 5 cycles while client 2 is valid → client_tready[2] stays 0 and client 1 completes first.
- Backpressure: axis_tready toggles 1,0,0,1 during a 4-beat packet → no beat lost or duplicated; axis_* stable while stalled; client_tready drops when the buffer is full.
- Assert rst_n=0 after beat 2 of 4, then release and send a new packet from client 3 → all outputs 0 during reset; pkt_count=0; only client 3's beats appear, tid=3.
- Client 2 finishes; clients 1 and 3 are both valid → client 3 is granted next (rr_ptr=3), then client 1.
